// File: rtl/maxpool_2x2_engine_if.sv
// maxpool_2x2_engine_if: controller handshake plus feature-buffer read and pooled-buffer write ports.
interface maxpool_2x2_engine_if #(
    parameter int DW = 16,
    parameter int AW = 12
);
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    modport master (
        input  start, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );
    modport slave (
        output start, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/maxpool_2x2_engine.sv
// maxpool_2x2_engine: 2x2 stride-2 signed max-pool over a CH x H x W map, one window every 4 cycles.
module maxpool_2x2_engine #(
    parameter int DW = 16,
    parameter int W  = 28,
    parameter int H  = 28,
    parameter int CH = 4,
    parameter int AW = $clog2(CH*H*W)
) (
    input logic clk,
    input logic rst_n,
    maxpool_2x2_engine_if.master bus
);
    localparam int W2 = W/2;
    localparam int H2 = H/2;
    localparam int N  = CH*H2*W2;
    typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;
    state_t state, state_nx;
    logic rd_en, v1, wr_en;
    logic [1:0] e, e1;
    logic [AW-1:0] x2, r2, c, widx;
    logic [DW-1:0] acc;
    logic last_x, last_r, last_c, last_rd, last_wr;
    assign last_x  = x2 == AW'(W2-1);
    assign last_r  = r2 == AW'(H2-1);
    assign last_c  = c == AW'(CH-1);
    assign last_rd = &e && last_x && last_r && last_c;
    assign last_wr = wr_en && widx == AW'(N-1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // HOLD absorbs the start level the controller still drives during done
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = last_wr ? DONE : RUN;
            DONE:    state_nx = HOLD;
            HOLD:    state_nx = bus.start ? HOLD : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_en <= 1'b0;
            e     <= '0;
            x2    <= '0;
            r2    <= '0;
            c     <= '0;
            v1    <= 1'b0;
            e1    <= '0;
            acc   <= '0;
            wr_en <= 1'b0;
            widx  <= '0;
        end else begin
            rd_en <= (state == IDLE && bus.start) || (rd_en && !last_rd);
            if (rd_en) begin
                e <= e + 2'd1;
                if (&e) begin
                    x2 <= last_x ? '0 : x2 + AW'(1);
                    if (last_x) begin
                        r2 <= last_r ? '0 : r2 + AW'(1);
                        if (last_r) c <= last_c ? '0 : c + AW'(1);
                    end
                end
            end
            v1 <= rd_en;
            e1 <= e;
            // equal values keep the accumulator; element 0 always loads
            if (v1) acc <= (e1 == 2'd0 || $signed(bus.rd_data) > $signed(acc)) ? bus.rd_data : acc;
            wr_en <= v1 && &e1;
            if (wr_en) widx <= last_wr ? '0 : widx + AW'(1);
        end
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = AW'(int'(c)*H*W + (2*int'(r2) + int'(e[1]))*W + 2*int'(x2) + int'(e[0]));
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = widx;
    assign bus.wr_data = acc;
    assign bus.busy    = state == RUN || state == DONE;
    assign bus.done    = state == DONE;
endmodule
